// File: rtl/sine_scroll_layer.sv
// sine_scroll_layer
// Animated sine-wave layer for the demo compositor. Each pixel column maps to a
// phase in a 64-column sine period. The curve row is drawn in white. A rainbow
// trail runs from the curve back toward the centre row. A frame-driven phase
// scroll, a runtime amplitude shift and a palette rotation animate the layer.
// The pixel path is a 2-stage register pipeline that accepts one pixel per
// cycle and never stalls.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   frame_tick   one-cycle pulse per frame; advances scroll and rotation
//   enable       scroll enable, sampled on frame_tick
//   speed[2:0]   phase increment per frame_tick
//   amp[1:0]     amplitude shift: curve height = T >> amp
//   rot_en       palette rotation enable, sampled on frame_tick
//   pixel_valid  x/y valid this cycle
//   x, y         pixel coordinate
//   rgb_valid    pixel_valid delayed by two cycles
//   sine_rgb     RRGGBB colour, zero whenever rgb_valid is low
module sine_scroll_layer #(
    parameter int X_BITS  = 6,
    parameter int Y_BITS  = 5,
    parameter int CENTRE  = 10,
    parameter int TRAIL   = 7,
    parameter int ROT_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic              enable,
    input  logic [2:0]        speed,
    input  logic [1:0]        amp,
    input  logic              rot_en,
    input  logic              pixel_valid,
    input  logic [X_BITS-1:0] x,
    input  logic [Y_BITS-1:0] y,
    output logic              rgb_valid,
    output logic [5:0]        sine_rgb
);

    // Curve row width: one sign bit above the y range.
    localparam int RW = Y_BITS + 1;
    // Stage-2 arithmetic width: y - r never overflows here.
    localparam int DW = Y_BITS + 2;

    localparam logic signed [RW-1:0] CENTRE_R = RW'(CENTRE);
    localparam logic signed [DW-1:0] CENTRE_D = DW'(CENTRE);
    localparam logic signed [DW-1:0] Y_MAX_D  = DW'(CENTRE + 10);
    localparam logic signed [DW-1:0] TRAIL_D  = DW'(TRAIL);
    localparam logic [7:0]           DIV_LAST = 8'(ROT_DIV - 1);

    // First quarter of the sine period, scaled to a peak of 10 rows.
    function automatic logic [3:0] quarter_lut(input logic [3:0] idx);
        logic [3:0] v;
        case (idx)
            4'd0:    v = 4'd0;
            4'd1:    v = 4'd1;
            4'd2:    v = 4'd2;
            4'd3:    v = 4'd3;
            4'd4:    v = 4'd4;
            4'd5:    v = 4'd5;
            4'd6:    v = 4'd6;
            4'd7:    v = 4'd6;
            4'd8:    v = 4'd7;
            4'd9:    v = 4'd8;
            4'd10:   v = 4'd8;
            4'd11:   v = 4'd9;
            4'd12:   v = 4'd9;
            default: v = 4'd10;
        endcase
        return v;
    endfunction

    function automatic logic [5:0] palette(input logic [2:0] idx);
        logic [5:0] c;
        case (idx)
            3'd0:    c = 6'b11_00_00;
            3'd1:    c = 6'b11_10_00;
            3'd2:    c = 6'b11_11_00;
            3'd3:    c = 6'b00_11_00;
            3'd4:    c = 6'b00_10_11;
            3'd5:    c = 6'b00_00_11;
            default: c = 6'b10_00_11;
        endcase
        return c;
    endfunction

    // Reduce a sum in 0..12 modulo 7.
    function automatic logic [2:0] wrap7(input logic [3:0] s);
        logic [3:0] r;
        r = (s >= 4'd7) ? (s - 4'd7) : s;
        return r[2:0];
    endfunction

    // Animation state
    logic [5:0] phase;
    logic [2:0] rot;
    logic [7:0] div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            rot   <= '0;
            div   <= '0;
        end else if (frame_tick) begin
            if (enable) begin
                phase <= phase + {3'b000, speed};
            end
            if (rot_en) begin
                if (div == DIV_LAST) begin
                    div <= '0;
                    rot <= (rot == 3'd6) ? 3'd0 : rot + 3'd1;
                end else begin
                    div <= div + 8'd1;
                end
            end
        end
    end

    // ---- stage p0: phase lookup and curve row (combinational) ----
    logic [5:0]             ph_p0;
    logic [3:0]             idx_p0;
    logic [3:0]             mag_p0;
    logic signed [RW-1:0]   mag_s_p0;
    logic signed [RW-1:0]   h_p0;
    logic signed [RW-1:0]   r_p0;

    always_comb begin
        ph_p0    = x[5:0] + phase;
        // Odd quarters run the table backwards: 15 - i is the bitwise inverse.
        idx_p0   = ph_p0[4] ? ~ph_p0[3:0] : ph_p0[3:0];
        mag_p0   = quarter_lut(idx_p0) >> amp;
        mag_s_p0 = signed'(RW'(mag_p0));
        h_p0     = ph_p0[5] ? -mag_s_p0 : mag_s_p0;
        r_p0     = CENTRE_R - h_p0;
    end

    // ---- stage p1: registered curve row, forwarded y and palette offset ----
    logic                   vld_p1;
    logic signed [RW-1:0]   r_p1;
    logic [Y_BITS-1:0]      y_p1;
    logic [2:0]             rot_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= pixel_valid;
        end
    end

    // The rotation value is captured with the pixel so later palette steps
    // never recolour a pixel already in flight.
    always_ff @(posedge clk) begin
        r_p1   <= r_p0;
        y_p1   <= y;
        rot_p1 <= rot;
    end

    logic signed [DW-1:0]   y_s_p1;
    logic signed [DW-1:0]   r_s_p1;
    logic signed [DW-1:0]   diff_p1;
    logic signed [DW-1:0]   dist_p1;
    logic                   on_curve_p1;
    logic                   in_trail_p1;
    logic [3:0]             pal_sum_p1;
    logic [5:0]             rgb_p1;

    always_comb begin
        y_s_p1      = signed'(DW'(y_p1));
        r_s_p1      = DW'(r_p1);
        diff_p1     = y_s_p1 - r_s_p1;
        dist_p1     = (diff_p1 < 0) ? -diff_p1 : diff_p1;
        on_curve_p1 = (diff_p1 == 0);
        // The trail only exists on the centre side of the curve. For a flat
        // curve (r == CENTRE) both ranges are empty, so only white is drawn.
        in_trail_p1 = ((r_s_p1 < CENTRE_D) && (y_s_p1 > r_s_p1) && (y_s_p1 <= CENTRE_D)) ||
                      ((r_s_p1 > CENTRE_D) && (y_s_p1 < r_s_p1) && (y_s_p1 >= CENTRE_D));
        pal_sum_p1  = 4'(dist_p1[2:0]) - 4'd1 + 4'(rot_p1);
        rgb_p1      = 6'b00_00_00;
        if (vld_p1 && (y_s_p1 <= Y_MAX_D)) begin
            if (on_curve_p1) begin
                rgb_p1 = 6'b11_11_11;
            end else if (in_trail_p1 && (dist_p1 <= TRAIL_D)) begin
                rgb_p1 = palette(wrap7(pal_sum_p1));
            end
        end
    end

    // ---- stage p2: registered output ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_valid <= 1'b0;
            sine_rgb  <= '0;
        end else begin
            rgb_valid <= vld_p1;
            sine_rgb  <= rgb_p1;
        end
    end

endmodule

// File: tb/tb_sine_scroll_layer.sv
module tb_sine_scroll_layer;

    localparam int X_BITS  = 6;
    localparam int Y_BITS  = 5;
    localparam int CENTRE  = 10;
    localparam int TRAIL   = 7;
    localparam int ROT_DIV = 4;

    localparam logic [5:0] WHITE = 6'b111111;
    localparam logic [5:0] RED   = 6'b110000;
    localparam logic [5:0] ORNG  = 6'b111000;
    localparam logic [5:0] VIOL  = 6'b100011;
    localparam logic [5:0] BLACK = 6'b000000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_tick;
    logic              enable;
    logic [2:0]        speed;
    logic [1:0]        amp;
    logic              rot_en;
    logic              pixel_valid;
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic              rgb_valid;
    logic [5:0]        sine_rgb;

    always #5 clk = ~clk;

    sine_scroll_layer #(
        .X_BITS(X_BITS), .Y_BITS(Y_BITS), .CENTRE(CENTRE), .TRAIL(TRAIL), .ROT_DIV(ROT_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
        .speed(speed), .amp(amp), .rot_en(rot_en), .pixel_valid(pixel_valid),
        .x(x), .y(y), .rgb_valid(rgb_valid), .sine_rgb(sine_rgb)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: accumulated scroll and count of rotation ticks.
    int         m_phase;
    int         m_rticks;
    int         cur_amp;
    // Expectation for the pixel presented one step earlier.
    logic       p_vld;
    logic [5:0] p_rgb;
    string      p_name;

    localparam int TQ[16] = '{0, 1, 2, 3, 4, 5, 6, 6, 7, 8, 8, 9, 9, 10, 10, 10};
    localparam logic [5:0] PAL[7] = '{6'b110000, 6'b111000, 6'b111100, 6'b001100,
                                      6'b001011, 6'b000011, 6'b100011};

    function automatic logic [5:0] ref_rgb(input int xx, input int yy, input int ph,
                                           input int rt, input int am);
        int p, q, i, mag, h, r, d;
        bit between;
        p   = (xx + ph) % 64;
        q   = p / 16;
        i   = p % 16;
        mag = (q % 2 == 0) ? TQ[i] : TQ[15 - i];
        mag = mag >> am;
        h   = (q < 2) ? mag : -mag;
        r   = CENTRE - h;
        if (yy > CENTRE + 10) return BLACK;
        if (yy == r) return WHITE;
        d = (yy > r) ? yy - r : r - yy;
        if (h > 0)      between = (yy > r) && (yy <= CENTRE);
        else if (h < 0) between = (yy < r) && (yy >= CENTRE);
        else            between = 1'b0;
        if (between && d <= TRAIL) return PAL[(d - 1 + rt) % 7];
        return BLACK;
    endfunction

    function automatic logic [5:0] model_exp(input int xx, input int yy);
        return ref_rgb(xx, yy, m_phase, (m_rticks / ROT_DIV) % 7, cur_amp);
    endfunction

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got valid=%b rgb=%b, want valid=%b rgb=%b",
                     nm, act[6], act[5:0], exp[6], exp[5:0]);
        end
    endtask

    // One pixel-clock step. Inputs are applied 1 ns after a rising edge; the
    // output is checked 1 ns after the next rising edge against the pixel of
    // the previous step (2-cycle latency).
    task automatic step(input bit tick, input bit en, input int spd, input bit ren,
                        input bit pv, input int xx, input int yy,
                        input logic [5:0] exp_rgb, input string nm);
        frame_tick  = tick;
        enable      = en;
        speed       = 3'(spd);
        rot_en      = ren;
        amp         = 2'(cur_amp);
        pixel_valid = pv;
        x           = 6'(xx);
        y           = 5'(yy);
        @(posedge clk);
        if (tick && en)  m_phase = (m_phase + spd) % 64;
        if (tick && ren) m_rticks++;
        #1;
        check(p_name, {rgb_valid, sine_rgb}, {p_vld, p_rgb});
        p_vld  = pv;
        p_rgb  = pv ? exp_rgb : BLACK;
        p_name = nm;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, BLACK, "idle");
    endtask

    task automatic pix(input int xx, input int yy, input logic [5:0] e, input string nm);
        step(0, 0, 0, 0, 1, xx, yy, e, nm);
    endtask

    task automatic do_reset(input bit immediate);
        rst_n       = 1'b0;
        frame_tick  = 1'b0;
        enable      = 1'b0;
        speed       = '0;
        rot_en      = 1'b0;
        amp         = '0;
        pixel_valid = 1'b0;
        x           = '0;
        y           = '0;
        cur_amp     = 0;
        m_phase     = 0;
        m_rticks    = 0;
        p_vld       = 1'b0;
        p_rgb       = BLACK;
        p_name      = "after_reset";
        #1;
        if (immediate) check("reset_async_out", {rgb_valid, sine_rgb}, 7'd0);
        @(posedge clk);
        #1;
        check("reset_out", {rgb_valid, sine_rgb}, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         xx;
        int         yy;
        int         am;
        logic [5:0] rgb;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 10, 0, WHITE};
        tbl[1]  = '{0, 11, 0, BLACK};
        tbl[2]  = '{16, 0, 0, WHITE};
        tbl[3]  = '{16, 1, 0, RED};
        tbl[4]  = '{16, 7, 0, VIOL};
        tbl[5]  = '{16, 8, 0, BLACK};
        tbl[6]  = '{48, 20, 0, WHITE};
        tbl[7]  = '{48, 19, 0, RED};
        tbl[8]  = '{16, 5, 1, WHITE};
        tbl[9]  = '{16, 6, 1, RED};
        tbl[10] = '{16, 0, 1, BLACK};
        tbl[11] = '{16, 9, 3, WHITE};
        tbl[12] = '{16, 10, 3, RED};

        do_reset(1'b0);
        idle();
        // Static curve at phase 0, one pixel per cycle.
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].am != cur_amp) begin
                cur_amp = tbl[i].am;
                idle();
            end
            pix(tbl[i].xx, tbl[i].yy, tbl[i].rgb, $sformatf("tbl%0d", i));
        end
        idle();

        // Scroll: two ticks at speed 3 give phase 6.
        do_reset(1'b0);
        step(1, 1, 3, 0, 0, 0, 0, BLACK, "idle");
        step(1, 1, 3, 0, 0, 0, 0, BLACK, "idle");
        pix(10, 0, WHITE, "scroll_x10y0");
        pix(10, 1, RED, "scroll_x10y1");
        idle();

        // Phase wrap: 31 ticks at speed 2 reach 62, one tick at speed 3 gives 1.
        do_reset(1'b0);
        for (int i = 0; i < 31; i++) step(1, 1, 2, 0, 0, 0, 0, BLACK, "idle");
        step(1, 1, 3, 0, 0, 0, 0, BLACK, "idle");
        pix(63, 10, WHITE, "wrap_x63y10");
        pix(63, 11, BLACK, "wrap_x63y11");
        idle();

        // Rotation: the 4th tick steps the palette; a coincident pixel keeps the old colour.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0, 0, BLACK, "idle");
        step(1, 0, 0, 1, 1, 16, 1, RED, "rot_coincident");
        pix(16, 1, ORNG, "rot_step1");
        step(1, 0, 0, 0, 0, 0, 0, BLACK, "idle");
        pix(16, 1, ORNG, "rot_hold");
        for (int i = 0; i < 24; i++) step(1, 0, 0, 1, 0, 0, 0, BLACK, "idle");
        pix(16, 1, RED, "rot_wrap7");
        idle();

        // Randomised stream against the reference model, with a mid-stream reset.
        do_reset(1'b0);
        for (int k = 0; k < 300; k++) begin
            bit         tk, en, ren, pv;
            int         spd, xx, yy;
            logic [5:0] e;
            if (k == 150) begin
                pix(16, 0, WHITE, "pre_midrst");
                #2;
                rst_n = 1'b0;
                #1;
                check("midrst_async_out", {rgb_valid, sine_rgb}, 7'd0);
                do_reset(1'b0);
                pix(16, 0, WHITE, "post_rst_phase0");
                pix(16, 1, RED, "post_rst_rot0");
            end
            tk  = ($urandom % 6) == 0;
            en  = ($urandom % 4) != 0;
            ren = ($urandom % 2) != 0;
            spd = $urandom % 8;
            pv  = ($urandom % 4) != 0;
            xx  = $urandom % 64;
            yy  = ($urandom % 4 == 0) ? ($urandom % 32) : ($urandom % 22);
            if (!pv && ($urandom % 3 == 0)) cur_amp = $urandom % 4;
            e = model_exp(xx, yy);
            step(tk, en, spd, ren, pv, xx, yy, e, $sformatf("rand%0d", k));
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
